// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests from the icache and feeds the IF/ID
// register. It absorbs miss latency, stalls, redirects and halt.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instruction_in,
  output logic [31:0] PCplus4_in,
  output logic        ifid_enable,
  output logic        ifid_flush
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t      state;
  logic [31:0] pc, pc4, rpc;
  logic [31:0] buf_instr, buf_npc;
  logic        pend_valid;
  logic [31:0] pend_pc;

  assign pc4 = pc + 32'd4;
  assign rpc = redirect_pc & ~32'h3;

  always_comb begin
    imemREN        = (state == FETCH);
    imemaddr       = pc;
    instruction_in = buf_instr;
    PCplus4_in     = buf_npc;
    ifid_enable    = 1'b0;
    ifid_flush     = 1'b0;
    case (state)
      FETCH: begin
        ifid_flush = halt | redirect_valid;
        // a hit that lands on a pending redirect is wrong-path data
        if (!halt && ihit && !redirect_valid && !pend_valid) begin
          instruction_in = imemload;
          PCplus4_in     = pc4;
          ifid_enable    = !stall;
        end
      end
      HOLD: begin
        ifid_flush  = halt | redirect_valid;
        ifid_enable = !halt && !redirect_valid && !stall;
      end
      HALT:    ifid_flush = halt;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      pc         <= PC_INIT;
      buf_instr  <= '0;
      buf_npc    <= '0;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (halt) state <= HALT;
          else if (ihit) begin
            pend_valid <= 1'b0;
            if (redirect_valid)  pc <= rpc;
            else if (pend_valid) pc <= pend_pc;
            else begin
              pc <= pc4;
              if (stall) begin
                buf_instr <= imemload;
                buf_npc   <= pc4;
                state     <= HOLD;
              end
            end
          end else if (redirect_valid) begin
            // keep the miss address stable; newest redirect wins
            pend_valid <= 1'b1;
            pend_pc    <= rpc;
          end
        end
        HOLD: begin
          if (halt) state <= HALT;
          else if (redirect_valid) begin
            pc    <= rpc;
            state <= FETCH;
          end else if (!stall) state <= FETCH;
        end
        HALT:    ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan steps then random traffic, all checked
// against a transaction-level model of the fetch stream.
module tb_fetch_stage;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, stall, redirect_valid, halt;
  logic [31:0] imemload, redirect_pc;
  logic        imemREN, ifid_enable, ifid_flush;
  logic [31:0] imemaddr, instruction_in, PCplus4_in;

  int checks = 0, passes = 0, fails = 0;

  fetch_stage #(.PC_INIT(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .instruction_in(instruction_in), .PCplus4_in(PCplus4_in),
    .ifid_enable(ifid_enable), .ifid_flush(ifid_flush)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h2000_0000 + (a >> 2);
  endfunction

  assign imemload = mem(imemaddr);

  // Model: where the stream is, what is parked, and which redirect is owed.
  bit          m_started, m_halted, m_parked, m_owed;
  logic [31:0] m_pc, m_park_instr, m_park_npc, m_owed_pc;

  task automatic model_reset();
    m_started = 0; m_halted = 0; m_parked = 0; m_owed = 0;
    m_pc = 32'h0; m_park_instr = 0; m_park_npc = 0; m_owed_pc = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model.
  task automatic cyc(input bit h, input bit s, input bit rv, input logic [31:0] rp, input bit hl);
    bit e_ren, e_en, e_fl;
    logic [31:0] e_ins, e_npc;
    ihit = h; stall = s; redirect_valid = rv; redirect_pc = rp; halt = hl;
    #1;
    e_ren = 0; e_en = 0; e_fl = 0; e_ins = 0; e_npc = 0;
    if (m_started && !m_halted) begin
      e_fl = hl || rv;
      if (m_parked) begin
        e_en = !hl && !rv && !s; e_ins = m_park_instr; e_npc = m_park_npc;
      end else begin
        e_ren = 1;
        e_en  = !hl && h && !rv && !m_owed && !s;
        e_ins = mem(m_pc); e_npc = m_pc + 32'd4;
      end
    end else if (m_halted) e_fl = hl;
    chk("imemREN", {31'b0, imemREN}, {31'b0, e_ren});
    chk("imemaddr", imemaddr, m_pc);
    chk("ifid_enable", {31'b0, ifid_enable}, {31'b0, e_en});
    chk("ifid_flush", {31'b0, ifid_flush}, {31'b0, e_fl});
    if (e_en) begin
      chk("instruction_in", instruction_in, e_ins);
      chk("PCplus4_in", PCplus4_in, e_npc);
    end
    @(posedge CLK);
    if (!m_started) m_started = 1;
    else if (m_halted) ;
    else if (hl) m_halted = 1;
    else if (m_parked) begin
      if (rv) begin m_pc = rp & ~32'h3; m_parked = 0; end
      else if (!s) m_parked = 0;
    end else if (h) begin
      if (rv) begin m_pc = rp & ~32'h3; m_owed = 0; end
      else if (m_owed) begin m_pc = m_owed_pc; m_owed = 0; end
      else begin
        if (s) begin m_parked = 1; m_park_instr = mem(m_pc); m_park_npc = m_pc + 32'd4; end
        m_pc = m_pc + 32'd4;
      end
    end else if (rv) begin m_owed = 1; m_owed_pc = rp & ~32'h3; end
    @(negedge CLK);
  endtask

  task automatic reset_outputs_check();
    chk("rst_imemREN", {31'b0, imemREN}, 32'h0);
    chk("rst_imemaddr", imemaddr, 32'h0);
    chk("rst_enable", {31'b0, ifid_enable}, 32'h0);
    chk("rst_flush", {31'b0, ifid_flush}, 32'h0);
    chk("rst_instr", instruction_in, 32'h0);
    chk("rst_pc4", PCplus4_in, 32'h0);
  endtask

  initial begin
    logic [31:0] rp;
    nRST = 0; ihit = 0; stall = 0; redirect_valid = 0; redirect_pc = 0; halt = 0;
    model_reset();
    #1 reset_outputs_check();
    @(negedge CLK); @(negedge CLK);
    nRST = 1;
    cyc(1, 0, 0, 0, 0);                      // IDLE cycle
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);  // pc 0, 4
    // stall hold on the hit at pc=8
    cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
    chk("hold_instr", instruction_in, 32'h2000_0002);
    cyc(1, 0, 0, 0, 0);                      // release: mem[2] enabled
    chk("after_hold_addr", imemaddr, 32'hC);
    cyc(1, 0, 0, 0, 0);                      // pc 0xC
    // redirect during miss at 0x10
    cyc(0, 0, 1, 32'h40, 0);
    cyc(0, 0, 0, 0, 0);
    chk("miss_addr_held", imemaddr, 32'h10);
    cyc(1, 0, 0, 0, 0);                      // discarded
    chk("redir_addr", imemaddr, 32'h40);
    // collision: redirect + ihit + stall
    cyc(1, 1, 1, 32'h80, 0);
    chk("coll_addr", imemaddr, 32'h80);
    chk("coll_ren", {31'b0, imemREN}, 32'h1);
    // park at 0x80, then redirect to 0x43 while parked
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 1, 32'h43, 0);
    chk("hold_redir_addr", imemaddr, 32'h40);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0, rp, 1'b0);
    end
    // halt, then activity that must be ignored
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'b0);
    // reset mid-miss
    nRST = 0; #2 model_reset(); #1 reset_outputs_check();
    @(negedge CLK); nRST = 1;
    cyc(0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    ihit = 0; #2 nRST = 0; model_reset();
    #1 reset_outputs_check();
    @(negedge CLK); nRST = 1;
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
